zstd_frame_header_parser: RTL and testbench
===========================================

ZSTD_FRAME_HEADER_PARSER -- requirements
Module: zstd_frame_header_parser

Interface
REQ-001 The block SHALL have parameter BYTES_PER_BEAT, default 2, meaning input bytes per beat; legal values 1, 2, 4.
REQ-002 The block SHALL have the port clk, input, 1 bit: clock.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: begin a new parse; honoured only in IDLE.
REQ-005 The block SHALL have the ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8*BYTES_PER_BEAT): header byte stream; lane 0 (bits 7:0) is the earliest byte.
REQ-006 The block SHALL have the ports hdr_valid (output, 1) and hdr_ready (input, 1): result handshake.
REQ-007 The block SHALL have the result outputs single_segment (1), checksum_flag (1), window_desc (8), dict_id (32), fcs (64), header_bytes (5), tail_bytes (2) and err_code (2).
REQ-008 err_code SHALL encode 0=OK, 1=BAD_MAGIC, 2=RESERVED_BIT.

Function
REQ-009 States SHALL be IDLE, MAGIC, FHD, WD, DID, FCS, DONE.
REQ-010 start in IDLE SHALL cause a transition to MAGIC on the next cycle; start in any other state SHALL be ignored.
REQ-011 in_ready SHALL be high only in MAGIC, FHD, WD, DID and FCS.
REQ-012 A beat SHALL be consumed only when in_valid && in_ready; when in_valid is low, all state SHALL hold.
REQ-013 Within one beat, bytes SHALL be walked lane 0 upward, and several fields/states SHALL be crossed in a single cycle as required.
REQ-014 MAGIC SHALL accept 4 bytes and compare them to 28 B5 2F FD; on mismatch, the block SHALL go to DONE with err_code=1 and consume no further beats.
REQ-015 FHD SHALL accept 1 byte and decode it as: FCS_flag=[7:6], single_segment=[5], reserved=[3], checksum_flag=[2], DID_flag=[1:0]; bit 4 SHALL be ignored.
REQ-016 If reserved=1, the block SHALL go to DONE with err_code=2.
REQ-017 WD SHALL be 1 byte when single_segment=0 and 0 bytes otherwise; window_desc SHALL be 0 when WD is absent.
REQ-018 DID SHALL be {0,1,2,4} bytes for DID_flag 0..3, assembled little-endian and zero-extended into dict_id.
REQ-019 FCS SHALL be {single_segment?1:0, 2, 4, 8} bytes for FCS_flag 0..3, assembled little-endian into fcs.
REQ-020 In the 2-byte FCS case, fcs SHALL equal the raw value + 256, computed in 64-bit.
REQ-021 Any zero-length state SHALL be skipped without consuming a byte.
REQ-022 The block SHALL enter DONE in the cycle after the beat holding the last header byte is accepted, and hdr_valid SHALL be high in DONE.
REQ-023 header_bytes SHALL equal the total header length (6..18, or 4 on BAD_MAGIC, or 5 on RESERVED_BIT).
REQ-024 tail_bytes SHALL equal the number of unused bytes above the last header byte in the final accepted beat (0..BYTES_PER_BEAT-1).
REQ-025 All result outputs SHALL hold stable while hdr_valid && !hdr_ready.
REQ-026 hdr_valid && hdr_ready SHALL return the block to IDLE on the next cycle.
REQ-027 Result registers SHALL be cleared at entry to MAGIC.

Reset
REQ-028 Asynchronous reset SHALL force IDLE and drive in_ready=0, hdr_valid=0 and every result output to 0, including during a parse in progress.
REQ-029 After reset deasserts, the first beat SHALL be accepted only after a new start.

Structure
REQ-030 Package zstd_pkg SHALL hold the magic constant, the state enum, the err_code enum and functions for DID/FCS byte count by flag.
REQ-031 Per-lane byte decode SHALL reside in one sub-module, zstd_hdr_byte_step, which maps (state, remaining count, byte) to (next state, next count, field update); it SHALL be instantiated BYTES_PER_BEAT times in a chain.

Verification
REQ-032 B=2, beats 28 B5|2F FD|00 58 -> hdr_valid one cycle after the third beat; window_desc=0x58, header_bytes=6, tail_bytes=0, err_code=0.
REQ-033 B=4, beats 28 B5 2F FD|20 40 AA BB -> single_segment=1, fcs=0x40, header_bytes=6, tail_bytes=2.
REQ-034 B=1, FHD 0x63 followed by 44 33 22 11 and FCS 10 00 -> dict_id=0x11223344, fcs=0x110, header_bytes=11.
REQ-035 B=2, magic 28 B5 2F FC -> err_code=1, header_bytes=4, in_ready low from DONE; FHD 0x08 -> err_code=2.
REQ-036 hdr_ready held low 5 cycles -> outputs stable; in_valid gaps mid-FCS -> identical result; reset asserted during FCS -> IDLE with all outputs 0.

Source files
------------

// File: rtl/zstd_pkg.sv
// ---------------------------------------------------------------------------
// zstd_pkg
// Shared definitions for the Zstandard frame header parser: the frame magic
// number, the parser state and error encodings, the running parse record that
// is handed from byte lane to byte lane, and the field-length lookups.
// ---------------------------------------------------------------------------
package zstd_pkg;

    // Frame magic as it sits in memory (28 B5 2F FD), byte 0 in bits 7:0.
    localparam logic [31:0] ZSTD_MAGIC = 32'hFD2F_B528;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAGIC = 3'd1,
        ST_FHD   = 3'd2,
        ST_WD    = 3'd3,
        ST_DID   = 3'd4,
        ST_FCS   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK           = 2'd0,
        ERR_BAD_MAGIC    = 2'd1,
        ERR_RESERVED_BIT = 2'd2
    } err_e;

    // Everything the parser knows after some number of header bytes.
    // remain counts the bytes still owed to the current state.
    typedef struct packed {
        state_e      state;
        logic [3:0]  remain;
        logic        magicOk;
        logic        singleSeg;
        logic        checksumFlag;
        logic [1:0]  fcsFlag;
        logic [1:0]  didFlag;
        logic [7:0]  windowDesc;
        logic [31:0] dictId;
        logic [63:0] fcs;
        logic [4:0]  hdrBytes;
        err_e        err;
    } parse_t;

    // Dictionary ID length for DID_flag 0..3.
    function automatic logic [3:0] didBytes(input logic [1:0] flag);
        logic [3:0] n;
        case (flag)
            2'd0:    n = 4'd0;
            2'd1:    n = 4'd1;
            2'd2:    n = 4'd2;
            default: n = 4'd4;
        endcase
        return n;
    endfunction

    // Frame content size length; flag 0 only carries a byte for single-segment frames.
    function automatic logic [3:0] fcsBytes(input logic [1:0] flag, input logic singleSeg);
        logic [3:0] n;
        case (flag)
            2'd0:    n = singleSeg ? 4'd1 : 4'd0;
            2'd1:    n = 4'd2;
            2'd2:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Parse record loaded when a new parse begins.
    function automatic parse_t freshParse();
        parse_t p;
        p         = '0;
        p.state   = ST_MAGIC;
        p.remain  = 4'd4;
        p.magicOk = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/zstd_hdr_byte_step.sv
// ---------------------------------------------------------------------------
// zstd_hdr_byte_step
// Consumes one header byte: given the parse record before the byte, produces
// the record after it. Lanes whose incoming state is IDLE or DONE pass the
// record through untouched and report the byte as unused.
//   cur_i  : parse record before this lane's byte
//   byte_i : the header byte in this lane
//   nxt_o  : parse record after this lane's byte
//   used_o : high when the byte belonged to the header
// ---------------------------------------------------------------------------
import zstd_pkg::*;

module zstd_hdr_byte_step (
    input  parse_t     cur_i,
    input  logic [7:0] byte_i,
    output parse_t     nxt_o,
    output logic       used_o
);

    // Enter state s and fall through any field whose length is zero, so one
    // byte can cross several empty fields in the same lane.
    function automatic parse_t enterState(input parse_t p, input state_e s);
        parse_t r;
        r       = p;
        r.state = s;
        if (r.state == ST_FHD) begin
            r.remain = 4'd1;
        end
        if (r.state == ST_WD) begin
            r.remain = r.singleSeg ? 4'd0 : 4'd1;
            if (r.remain == 4'd0) r.state = ST_DID;
        end
        if (r.state == ST_DID) begin
            r.remain = didBytes(r.didFlag);
            if (r.remain == 4'd0) r.state = ST_FCS;
        end
        if (r.state == ST_FCS) begin
            r.remain = fcsBytes(r.fcsFlag, r.singleSeg);
            if (r.remain == 4'd0) r.state = ST_DONE;
        end
        return r;
    endfunction

    logic [3:0] pos;

    // Byte decode for the current state; multi-byte fields are little-endian,
    // so the byte position is (field length - bytes still owed).
    always_comb begin
        nxt_o  = cur_i;
        used_o = 1'b0;
        pos    = '0;
        case (cur_i.state)
            ST_MAGIC: begin
                used_o         = 1'b1;
                nxt_o.hdrBytes = cur_i.hdrBytes + 5'd1;
                pos            = 4'd4 - cur_i.remain;
                if (byte_i != ZSTD_MAGIC[{pos[1:0], 3'b000} +: 8]) nxt_o.magicOk = 1'b0;
                nxt_o.remain = cur_i.remain - 4'd1;
                if (cur_i.remain == 4'd1) begin
                    if (nxt_o.magicOk) begin
                        nxt_o = enterState(nxt_o, ST_FHD);
                    end else begin
                        nxt_o.state = ST_DONE;
                        nxt_o.err   = ERR_BAD_MAGIC;
                    end
                end
            end
            ST_FHD: begin
                used_o             = 1'b1;
                nxt_o.hdrBytes     = cur_i.hdrBytes + 5'd1;
                nxt_o.fcsFlag      = byte_i[7:6];
                nxt_o.singleSeg    = byte_i[5];
                nxt_o.checksumFlag = byte_i[2];
                nxt_o.didFlag      = byte_i[1:0];
                if (byte_i[3]) begin
                    nxt_o.state = ST_DONE;
                    nxt_o.err   = ERR_RESERVED_BIT;
                end else begin
                    nxt_o = enterState(nxt_o, ST_WD);
                end
            end
            ST_WD: begin
                used_o           = 1'b1;
                nxt_o.hdrBytes   = cur_i.hdrBytes + 5'd1;
                nxt_o.windowDesc = byte_i;
                nxt_o            = enterState(nxt_o, ST_DID);
            end
            ST_DID: begin
                used_o         = 1'b1;
                nxt_o.hdrBytes = cur_i.hdrBytes + 5'd1;
                pos            = didBytes(cur_i.didFlag) - cur_i.remain;
                nxt_o.dictId[{pos[1:0], 3'b000} +: 8] = byte_i;
                nxt_o.remain   = cur_i.remain - 4'd1;
                if (cur_i.remain == 4'd1) nxt_o = enterState(nxt_o, ST_FCS);
            end
            ST_FCS: begin
                used_o         = 1'b1;
                nxt_o.hdrBytes = cur_i.hdrBytes + 5'd1;
                pos            = fcsBytes(cur_i.fcsFlag, cur_i.singleSeg) - cur_i.remain;
                nxt_o.fcs[{pos[2:0], 3'b000} +: 8] = byte_i;
                nxt_o.remain   = cur_i.remain - 4'd1;
                if (cur_i.remain == 4'd1) begin
                    // The 2-byte size field is stored with a 256 offset.
                    if (cur_i.fcsFlag == 2'd1) nxt_o.fcs = nxt_o.fcs + 64'd256;
                    nxt_o.state = ST_DONE;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/zstd_frame_header_parser.sv
// ---------------------------------------------------------------------------
// zstd_frame_header_parser
// Parses a Zstandard frame header from a byte stream delivered BYTES_PER_BEAT
// bytes at a time (lane 0 earliest) and presents the decoded fields on a
// valid/ready result handshake.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : begin a parse (only acted on while idle)
//   in_valid/in_ready/in_data : header byte stream
//   hdr_valid/hdr_ready       : result handshake
//   single_segment, checksum_flag, window_desc, dict_id, fcs : decoded fields
//   header_bytes    : header length consumed
//   tail_bytes      : unused bytes above the header in the final beat
//   err_code        : 0 OK, 1 bad magic, 2 reserved bit set
// ---------------------------------------------------------------------------
import zstd_pkg::*;

module zstd_frame_header_parser #(
    parameter int BYTES_PER_BEAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*BYTES_PER_BEAT-1:0] in_data,
    output logic                        hdr_valid,
    input  logic                        hdr_ready,
    output logic                        single_segment,
    output logic                        checksum_flag,
    output logic [7:0]                  window_desc,
    output logic [31:0]                 dict_id,
    output logic [63:0]                 fcs,
    output logic [4:0]                  header_bytes,
    output logic [1:0]                  tail_bytes,
    output logic [1:0]                  err_code
);

    parse_t                      parseQ, parseD;
    logic [1:0]                  tailQ, tailD;
    logic                        inReadyQ, hdrValidQ;
    parse_t [BYTES_PER_BEAT:0]   lane;
    logic [BYTES_PER_BEAT-1:0]   laneUsed;
    logic [2:0]                  unusedCnt;

    assign lane[0] = parseQ;

    // One step per byte lane, chained so a whole beat is parsed in one cycle.
    for (genvar i = 0; i < BYTES_PER_BEAT; i++) begin : g_lane
        zstd_hdr_byte_step uStep (
            .cur_i  (lane[i]),
            .byte_i (in_data[8*i +: 8]),
            .nxt_o  (lane[i+1]),
            .used_o (laneUsed[i])
        );
    end

    // Unused lanes can only sit above the last header byte, so counting them
    // gives the tail of the final beat.
    always_comb begin
        unusedCnt = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            if (!laneUsed[i]) unusedCnt = unusedCnt + 3'd1;
        end
    end

    // Next parse record: start a parse from IDLE, absorb a beat while
    // consuming, release the result on the handshake.
    always_comb begin
        parseD = parseQ;
        tailD  = tailQ;
        case (parseQ.state)
            ST_IDLE: begin
                if (start) begin
                    parseD = freshParse();
                    tailD  = '0;
                end
            end
            ST_DONE: begin
                if (hdr_ready) parseD.state = ST_IDLE;
            end
            default: begin
                if (in_valid) begin
                    parseD = lane[BYTES_PER_BEAT];
                    tailD  = unusedCnt[1:0];
                end
            end
        endcase
    end

    // State, result and handshake registers; handshake outputs are decoded
    // from the next state so they line up with the registered state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parseQ    <= '0;
            tailQ     <= '0;
            inReadyQ  <= 1'b0;
            hdrValidQ <= 1'b0;
        end else begin
            parseQ    <= parseD;
            tailQ     <= tailD;
            inReadyQ  <= (parseD.state != ST_IDLE) && (parseD.state != ST_DONE);
            hdrValidQ <= (parseD.state == ST_DONE);
        end
    end

    assign in_ready       = inReadyQ;
    assign hdr_valid      = hdrValidQ;
    assign single_segment = parseQ.singleSeg;
    assign checksum_flag  = parseQ.checksumFlag;
    assign window_desc    = parseQ.windowDesc;
    assign dict_id        = parseQ.dictId;
    assign fcs            = parseQ.fcs;
    assign header_bytes   = parseQ.hdrBytes;
    assign tail_bytes     = tailQ;
    assign err_code       = parseQ.err;

endmodule

// File: tb/tb_zstd_frame_header_parser.sv
// ---------------------------------------------------------------------------
// tb_zstd_frame_header_parser
// Drives three parser instances (1, 2 and 4 bytes per beat) with directed
// header frames and checks results against a byte-level header model.
// ---------------------------------------------------------------------------
module tb_zstd_frame_header_parser;

    typedef struct {
        logic        ss;
        logic        cf;
        logic [7:0]  wd;
        logic [31:0] did;
        logic [63:0] fcs;
        int          hb;
        int          tb;
        int          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startS[3];
    logic        inValidS[3];
    logic        inReadyS[3];
    logic        hdrValidS[3];
    logic        hdrReadyS[3];
    logic [7:0]  inData1;
    logic [15:0] inData2;
    logic [31:0] inData4;
    logic        ssS[3];
    logic        cfS[3];
    logic [7:0]  wdS[3];
    logic [31:0] didS[3];
    logic [63:0] fcsS[3];
    logic [4:0]  hbS[3];
    logic [1:0]  tbS[3];
    logic [1:0]  errS[3];

    exp_t        expS[3];
    bit          armed[3];
    logic [143:0] frameBits;
    int          frameLen;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    zstd_frame_header_parser #(.BYTES_PER_BEAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(startS[0]), .in_valid(inValidS[0]),
        .in_ready(inReadyS[0]), .in_data(inData1), .hdr_valid(hdrValidS[0]),
        .hdr_ready(hdrReadyS[0]), .single_segment(ssS[0]), .checksum_flag(cfS[0]),
        .window_desc(wdS[0]), .dict_id(didS[0]), .fcs(fcsS[0]),
        .header_bytes(hbS[0]), .tail_bytes(tbS[0]), .err_code(errS[0])
    );

    zstd_frame_header_parser #(.BYTES_PER_BEAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(startS[1]), .in_valid(inValidS[1]),
        .in_ready(inReadyS[1]), .in_data(inData2), .hdr_valid(hdrValidS[1]),
        .hdr_ready(hdrReadyS[1]), .single_segment(ssS[1]), .checksum_flag(cfS[1]),
        .window_desc(wdS[1]), .dict_id(didS[1]), .fcs(fcsS[1]),
        .header_bytes(hbS[1]), .tail_bytes(tbS[1]), .err_code(errS[1])
    );

    zstd_frame_header_parser #(.BYTES_PER_BEAT(4)) dut4 (
        .clk(clk), .reset(reset), .start(startS[2]), .in_valid(inValidS[2]),
        .in_ready(inReadyS[2]), .in_data(inData4), .hdr_valid(hdrValidS[2]),
        .hdr_ready(hdrReadyS[2]), .single_segment(ssS[2]), .checksum_flag(cfS[2]),
        .window_desc(wdS[2]), .dict_id(didS[2]), .fcs(fcsS[2]),
        .header_bytes(hbS[2]), .tail_bytes(tbS[2]), .err_code(errS[2])
    );

    // Frame bytes are given most-significant-first: the first stream byte is
    // the leftmost byte of the n-byte literal. Bytes past the frame read as EE.
    task automatic setFrame(input logic [143:0] bits, input int n);
        frameBits = bits;
        frameLen  = n;
    endtask

    function automatic logic [7:0] byteAt(input int i);
        if (i < frameLen) return frameBits[8*(frameLen-1-i) +: 8];
        return 8'hEE;
    endfunction

    // Header model: walks the byte list following the frame header layout.
    function automatic exp_t modelHeader(input int bpb);
        exp_t       e;
        logic [7:0] fhd;
        int         pos;
        int         didLen;
        int         fcsLen;
        e = '{ss: 1'b0, cf: 1'b0, wd: 8'h0, did: 32'h0, fcs: 64'h0, hb: 0, tb: 0, err: 0};
        if ({byteAt(0), byteAt(1), byteAt(2), byteAt(3)} != 32'h28B52FFD) begin
            e.err = 1;
            e.hb  = 4;
        end else begin
            fhd = byteAt(4);
            if (fhd[3]) begin
                e.err = 2;
                e.hb  = 5;
            end else begin
                e.ss = fhd[5];
                e.cf = fhd[2];
                pos  = 5;
                if (!e.ss) begin
                    e.wd = byteAt(pos);
                    pos++;
                end
                didLen = (fhd[1:0] == 2'd3) ? 4 : int'(fhd[1:0]);
                for (int k = 0; k < didLen; k++) e.did = e.did | (32'(byteAt(pos + k)) << (8 * k));
                pos += didLen;
                case (fhd[7:6])
                    2'd0:    fcsLen = e.ss ? 1 : 0;
                    2'd1:    fcsLen = 2;
                    2'd2:    fcsLen = 4;
                    default: fcsLen = 8;
                endcase
                for (int k = 0; k < fcsLen; k++) e.fcs = e.fcs | (64'(byteAt(pos + k)) << (8 * k));
                if (fcsLen == 2) e.fcs = e.fcs + 64'd256;
                pos += fcsLen;
                e.hb = pos;
            end
        end
        e.tb = (bpb - (e.hb % bpb)) % bpb;
        return e;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Full result comparison against the model for instance d.
    task automatic checkOutput(input int d);
        string tag;
        tag = $sformatf("b%0d", 1 << d);
        checkVal({tag, "_err"},      64'(errS[d]), 64'(expS[d].err));
        checkVal({tag, "_hdrbytes"}, 64'(hbS[d]),  64'(expS[d].hb));
        checkVal({tag, "_tail"},     64'(tbS[d]),  64'(expS[d].tb));
        checkVal({tag, "_inready_done"}, 64'(inReadyS[d]), 64'd0);
        checkVal({tag, "_wd"},  64'(wdS[d]),  64'(expS[d].wd));
        checkVal({tag, "_did"}, 64'(didS[d]), 64'(expS[d].did));
        checkVal({tag, "_fcs"}, fcsS[d], expS[d].fcs);
        if (expS[d].err == 0) begin
            checkVal({tag, "_ss"}, 64'(ssS[d]), 64'(expS[d].ss));
            checkVal({tag, "_cf"}, 64'(cfS[d]), 64'(expS[d].cf));
        end
    endtask

    task automatic checkAllZero(input int d, input string tag);
        checkVal({tag, "_ctrl"}, 64'({inReadyS[d], hdrValidS[d], ssS[d], cfS[d], errS[d], tbS[d], hbS[d]}), 64'd0);
        checkVal({tag, "_wd_did"}, 64'({wdS[d], didS[d]}), 64'd0);
        checkVal({tag, "_fcs"}, fcsS[d], 64'd0);
    endtask

    task automatic setData(input int d, input int k);
        case (d)
            0:       inData1 = byteAt(k);
            1:       inData2 = {byteAt(2*k+1), byteAt(2*k)};
            default: inData4 = {byteAt(4*k+3), byteAt(4*k+2), byteAt(4*k+1), byteAt(4*k)};
        endcase
    endtask

    // Start a parse on instance d and feed beats while it is ready. gapAt
    // names the beat before which in_valid drops for gapLen cycles; a stray
    // start is pulsed during that gap.
    task automatic applyStimulus(input int d, input int gapAt, input int gapLen);
        int    bpb;
        int    k;
        int    gaps;
        int    cyc;
        bit    done;
        string tag;
        bpb  = 1 << d;
        k    = 0;
        gaps = 0;
        cyc  = 0;
        done = 1'b0;
        tag  = $sformatf("b%0d", bpb);
        expS[d]  = modelHeader(bpb);
        armed[d] = 1'b1;
        @(negedge clk);
        startS[d] = 1'b1;
        @(negedge clk);
        startS[d] = 1'b0;
        checkVal({tag, "_inready_after_start"}, 64'(inReadyS[d]), 64'd1);
        while (!done && cyc < 200) begin
            if (!inReadyS[d]) begin
                done = 1'b1;
            end else begin
                if (k == gapAt && gaps < gapLen) begin
                    inValidS[d] = 1'b0;
                    startS[d]   = (gaps == 0);
                    gaps++;
                end else begin
                    inValidS[d] = 1'b1;
                    startS[d]   = 1'b0;
                    setData(d, k);
                end
                @(posedge clk);
                if (inValidS[d]) k++;
                @(negedge clk);
                cyc++;
            end
        end
        inValidS[d] = 1'b0;
        startS[d]   = 1'b0;
        checkVal({tag, "_done_in_budget"}, 64'(done), 64'd1);
        checkVal({tag, "_hdr_valid_latency"}, 64'(hdrValidS[d]), 64'd1);
        checkVal({tag, "_beats"}, 64'(k), 64'((expS[d].hb + bpb - 1) / bpb));
    endtask

    // Hold hdr_ready low for holdCycles, then complete the handshake.
    task automatic releaseHeader(input int d, input int holdCycles);
        repeat (holdCycles) @(negedge clk);
        hdrReadyS[d] = 1'b1;
        @(negedge clk);
        hdrReadyS[d] = 1'b0;
        checkVal($sformatf("b%0d_back_to_idle", 1 << d), 64'({hdrValidS[d], inReadyS[d]}), 64'd0);
        armed[d] = 1'b0;
    endtask

    // Continuous comparison while a result is presented.
    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                if (armed[d] && hdrValidS[d]) checkOutput(d);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            startS[d]    = 1'b0;
            inValidS[d]  = 1'b0;
            hdrReadyS[d] = 1'b0;
            armed[d]     = 1'b0;
        end
        inData1   = '0;
        inData2   = '0;
        inData4   = '0;
        frameBits = '0;
        frameLen  = 0;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) checkAllZero(d, $sformatf("b%0d_reset", 1 << d));
        reset = 1'b0;

        // B=2 window descriptor only
        setFrame(144'h28B52FFD0058, 6);
        applyStimulus(1, -1, 0);
        checkVal("lit_b2_wd", 64'(wdS[1]), 64'h58);
        checkVal("lit_b2_hb", 64'(hbS[1]), 64'd6);
        checkVal("lit_b2_tail", 64'(tbS[1]), 64'd0);
        checkVal("lit_b2_err", 64'(errS[1]), 64'd0);
        releaseHeader(1, 0);

        // B=4 single segment, one-byte content size, two spare lanes
        setFrame(144'h28B52FFD2040AABB, 8);
        applyStimulus(2, -1, 0);
        checkVal("lit_b4_ss", 64'(ssS[2]), 64'd1);
        checkVal("lit_b4_fcs", fcsS[2], 64'h40);
        checkVal("lit_b4_hb", 64'(hbS[2]), 64'd6);
        checkVal("lit_b4_tail", 64'(tbS[2]), 64'd2);
        releaseHeader(2, 0);

        // B=1 four-byte dictionary ID and two-byte content size
        setFrame(144'h28B52FFD63443322111000, 11);
        applyStimulus(0, -1, 0);
        checkVal("lit_b1_did", 64'(didS[0]), 64'h11223344);
        checkVal("lit_b1_fcs", fcsS[0], 64'h110);
        checkVal("lit_b1_hb", 64'(hbS[0]), 64'd11);
        releaseHeader(0, 0);

        // B=2 bad magic; in_ready must stay low while the result waits
        setFrame(144'h28B52FFC, 4);
        applyStimulus(1, -1, 0);
        checkVal("lit_badmagic_err", 64'(errS[1]), 64'd1);
        checkVal("lit_badmagic_hb", 64'(hbS[1]), 64'd4);
        checkVal("lit_badmagic_inready", 64'(inReadyS[1]), 64'd0);
        releaseHeader(1, 3);

        // B=2 reserved bit set
        setFrame(144'h28B52FFD0877, 6);
        applyStimulus(1, -1, 0);
        checkVal("lit_reserved_err", 64'(errS[1]), 64'd2);
        checkVal("lit_reserved_hb", 64'(hbS[1]), 64'd5);
        releaseHeader(1, 0);

        // B=4 eight-byte content size, gap mid content size, result held 5 cycles
        setFrame(144'h28B52FFDC67ABEEF0102030405060708, 16);
        applyStimulus(2, 3, 3);
        checkVal("lit_b4_fcs8", fcsS[2], 64'h0807060504030201);
        checkVal("lit_b4_did2", 64'(didS[2]), 64'hEFBE);
        checkVal("lit_b4_hb16", 64'(hbS[2]), 64'd16);
        releaseHeader(2, 5);

        // B=2 four-byte content size with a gap and a stray start mid-field
        setFrame(144'h28B52FFD851199DEADBEEF, 11);
        applyStimulus(1, 4, 2);
        checkVal("lit_b2_fcs4", fcsS[1], 64'hEFBEADDE);
        checkVal("lit_b2_tail1", 64'(tbS[1]), 64'd1);
        releaseHeader(1, 0);

        // B=1 reset while the content size field is being collected
        @(negedge clk);
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            inValidS[0] = 1'b1;
            setData(0, k);
            @(negedge clk);
        end
        setData(0, 9);
        #2 reset = 1'b1;
        #1 checkAllZero(0, "rst_mid_fcs");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkVal("rst_no_start_busy", 64'({inReadyS[0], hdrValidS[0]}), 64'd0);
        end
        inValidS[0] = 1'b0;

        // B=1 recovery after reset
        setFrame(144'h28B52FFD63443322111000, 11);
        applyStimulus(0, -1, 0);
        releaseHeader(0, 0);

        // B=4 two-byte content size carrying into bit 16
        setFrame(144'h28B52FFD4000FFFF, 8);
        applyStimulus(2, -1, 0);
        checkVal("lit_b4_fcs_carry", fcsS[2], 64'h100FF);
        releaseHeader(2, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
